// File: rtl/intc.sv
// -----------------------------------------------------------------------------
// intc -- parametrised external interrupt controller (DBus slave)
//
// Collects NUM_SOURCES interrupt request lines through a per-source gateway
// (level or rising-edge), applies per-source enable/priority and a global
// threshold, and presents the best candidate as a registered irq / irq_id pair
// to the trap unit. Software takes an interrupt by reading CLAIM and hands it
// back by writing the ID to COMPLETE.
//
// Optional feature macro: INTC_SWTRIG_EN
//   defined   -> PENDING is write-1-to-set (byte strobes honoured)
//   undefined -> writes to PENDING are silently ignored
//
// Ports:
//   clk           system clock
//   rst_n         synchronous reset, active-low
//   src           raw interrupt request lines (already in clk domain)
//   rd_en, wr_en  DBus read / write strobes
//   addr          word address into the register window
//   wr_data       write data
//   wr_strobe     byte write enables
//   rd_data       read data (combinational, 0 when idle or unmapped)
//   access_fault  unmapped access (combinational)
//   irq           machine external interrupt request (registered)
//   irq_id        ID of the current best candidate, 0 = none (registered)
//
// Register map (word addresses):
//   0 PENDING  1 ENABLE  2 EDGE  3 THRESHOLD  4 CLAIM/COMPLETE
//   8.. PRIORITY, eight 4-bit fields per word
// -----------------------------------------------------------------------------
module intc #(
  parameter int NUM_SOURCES = 10,
  parameter int PRIO_WIDTH  = 3,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SOURCES-1:0] src,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [31:0]            wr_data,
  input  logic [3:0]             wr_strobe,
  output logic [31:0]            rd_data,
  output logic                   access_fault,
  output logic                   irq,
  output logic [4:0]             irq_id
);

  localparam int NUM_PRIO_WORDS = (NUM_SOURCES + 7) / 8;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] in_service_q, in_service_d;
  logic [NUM_SOURCES-1:0] enable_q, enable_d;
  logic [NUM_SOURCES-1:0] edge_q, edge_d;
  logic [NUM_SOURCES-1:0] prev_src_q;
  logic [PRIO_WIDTH-1:0]  threshold_q, threshold_d;
  logic                   irq_q, irq_d;
  logic [4:0]             irq_id_q, irq_id_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0] addr_w;
  logic [31:0] prio_word;
  logic sel_pend, sel_en, sel_edge, sel_thr, sel_claim, sel_prio, mapped;

  assign addr_w    = 32'(addr);
  assign prio_word = addr_w - 32'd8;
  assign sel_pend  = (addr_w == 32'd0);
  assign sel_en    = (addr_w == 32'd1);
  assign sel_edge  = (addr_w == 32'd2);
  assign sel_thr   = (addr_w == 32'd3);
  assign sel_claim = (addr_w == 32'd4);
  // Only priority words that hold at least one implemented source are mapped.
  assign sel_prio  = (addr_w >= 32'd8) && (addr_w < 32'(8 + NUM_PRIO_WORDS));
  assign mapped    = sel_pend | sel_en | sel_edge | sel_thr | sel_claim | sel_prio;

  assign access_fault = (rd_en | wr_en) & ~mapped;

  // ---------------------------------------------------------------------------
  // Per-source logic: gateway, claim/complete decode, priority register
  // ---------------------------------------------------------------------------
  logic [NUM_SOURCES-1:0]            bit_strobe;
  logic [NUM_SOURCES-1:0]            gw_set;
  logic [NUM_SOURCES-1:0]            sw_set;
  logic [NUM_SOURCES-1:0]            claim_mask;
  logic [NUM_SOURCES-1:0]            complete_mask;
  logic [NUM_SOURCES-1:0]            eligible;
  logic [NUM_SOURCES*PRIO_WIDTH-1:0] prio_all;
  logic                              claim_hit;
  logic                              complete_en;

  // Claim acts on every edge rd_en is held at CLAIM, but only if there is a
  // candidate; the pre-edge irq_id selects the source.
  assign claim_hit   = rd_en & sel_claim & (irq_id_q != 5'd0);
  assign complete_en = wr_en & sel_claim & wr_strobe[0];

  generate
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      localparam int WORD = gi / 8;
      localparam int LSB  = 4 * (gi % 8);

      logic [PRIO_WIDTH-1:0] prio_q, prio_d;

      assign bit_strobe[gi] = wr_strobe[gi / 8];

      // Level mode is masked while in service so a held line does not
      // re-pend until completion; edge mode latches every new rising edge.
      assign gw_set[gi] = edge_q[gi] ? (src[gi] & ~prev_src_q[gi])
                                     : (src[gi] & ~in_service_q[gi]);

      assign claim_mask[gi]    = claim_hit & (irq_id_q == 5'(gi + 1));
      // IDs 0 and out-of-range never match a source, so they fall away here.
      assign complete_mask[gi] = complete_en & (wr_data[4:0] == 5'(gi + 1));

      always_comb begin
        prio_d = prio_q;
        if (wr_en && sel_prio && (prio_word == 32'(WORD)) && wr_strobe[LSB / 8]) begin
          prio_d = wr_data[LSB +: PRIO_WIDTH];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          prio_q <= '0;
        end else begin
          prio_q <= prio_d;
        end
      end

      assign prio_all[gi*PRIO_WIDTH +: PRIO_WIDTH] = prio_q;
      assign eligible[gi] = pending_q[gi] & enable_q[gi] & ~in_service_q[gi]
                          & (prio_q > threshold_q);
    end
  endgenerate

`ifdef INTC_SWTRIG_EN
  assign sw_set = (wr_en && sel_pend) ? (wr_data[NUM_SOURCES-1:0] & bit_strobe) : '0;
`else
  assign sw_set = '0;
`endif

  // ---------------------------------------------------------------------------
  // Register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    enable_d    = enable_q;
    edge_d      = edge_q;
    threshold_d = threshold_q;

    if (wr_en && sel_en) begin
      enable_d = (enable_q & ~bit_strobe) | (wr_data[NUM_SOURCES-1:0] & bit_strobe);
    end
    if (wr_en && sel_edge) begin
      edge_d = (edge_q & ~bit_strobe) | (wr_data[NUM_SOURCES-1:0] & bit_strobe);
    end
    if (wr_en && sel_thr && wr_strobe[0]) begin
      threshold_d = wr_data[PRIO_WIDTH-1:0];
    end

    // A same-cycle gateway set overrides the claim clear.
    pending_d    = (pending_q & ~claim_mask) | gw_set | sw_set;
    in_service_d = (in_service_q | claim_mask) & ~complete_mask;
  end

  // ---------------------------------------------------------------------------
  // Arbitration: highest priority wins, strict compare keeps the lowest ID
  // on ties because sources are scanned in ascending order.
  // ---------------------------------------------------------------------------
  logic [PRIO_WIDTH-1:0] best_prio;
  logic [4:0]            best_id;

  always_comb begin
    best_prio = '0;
    best_id   = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (eligible[i] && (prio_all[i*PRIO_WIDTH +: PRIO_WIDTH] > best_prio)) begin
        best_prio = prio_all[i*PRIO_WIDTH +: PRIO_WIDTH];
        best_id   = 5'(i + 1);
      end
    end
    irq_id_d = best_id;
    irq_d    = (best_id != 5'd0);
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
      edge_q       <= '0;
      prev_src_q   <= '0;
      threshold_q  <= '0;
      irq_q        <= 1'b0;
      irq_id_q     <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      enable_q     <= enable_d;
      edge_q       <= edge_d;
      prev_src_q   <= src;
      threshold_q  <= threshold_d;
      irq_q        <= irq_d;
      irq_id_q     <= irq_id_d;
    end
  end

  assign irq    = irq_q;
  assign irq_id = irq_id_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] prio_rd;

  always_comb begin
    prio_rd = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (prio_word == 32'(i / 8)) begin
        prio_rd[4*(i%8) +: PRIO_WIDTH] = prio_all[i*PRIO_WIDTH +: PRIO_WIDTH];
      end
    end

    rd_data = '0;
    if (rd_en) begin
      if (sel_pend)       rd_data = 32'(pending_q);
      else if (sel_en)    rd_data = 32'(enable_q);
      else if (sel_edge)  rd_data = 32'(edge_q);
      else if (sel_thr)   rd_data = 32'(threshold_q);
      else if (sel_claim) rd_data = 32'(irq_id_q);
      else if (sel_prio)  rd_data = prio_rd;
    end
  end

  // Upper data/strobe bits are architecturally ignored for most registers.
  logic unused_inputs;
  assign unused_inputs = ^{wr_data, wr_strobe};

endmodule

// File: tb/tb_intc.sv
module tb_intc;
  localparam int N     = 10;
  localparam int PW    = 3;
  localparam int AW    = 4;
  localparam int PMASK = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  src = '0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wr_data = '0;
  logic [3:0]    wr_strobe = '0;
  logic [31:0]   rd_data;
  logic          access_fault;
  logic          irq;
  logic [4:0]    irq_id;

  always #5 clk = ~clk;

  intc #(.NUM_SOURCES(N), .PRIO_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .src(src), .rd_en(rd_en), .wr_en(wr_en),
    .addr(addr), .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
    .access_fault(access_fault), .irq(irq), .irq_id(irq_id)
  );

  int vectors = 0;
  int miscompares = 0;
  int txn = 0;
  logic [31:0] last_rd;
  logic        last_fault;

  // ---------------- behavioural reference model ----------------
  bit m_pend[N], m_isv[N], m_en[N], m_edge[N], m_prev[N];
  int m_prio[N];
  int m_thr, m_irq_id;
  bit m_irq;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_isv[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_prev[i] = 0; m_prio[i] = 0;
    end
    m_thr = 0; m_irq_id = 0; m_irq = 0;
  endfunction

  function automatic bit model_mapped(int a);
    return (a >= 0 && a <= 4) || (a >= 8 && a < 8 + (N + 7) / 8);
  endfunction

  function automatic logic [31:0] model_read(int a);
    logic [31:0] v;
    v = '0;
    if (!model_mapped(a)) return v;
    case (a)
      0: for (int i = 0; i < N; i++) v[i] = m_pend[i];
      1: for (int i = 0; i < N; i++) v[i] = m_en[i];
      2: for (int i = 0; i < N; i++) v[i] = m_edge[i];
      3: v = 32'(m_thr);
      4: v = 32'(m_irq_id);
      default:
        for (int i = 0; i < N; i++)
          if (i / 8 == a - 8) v = v | (32'(m_prio[i]) << (4 * (i % 8)));
    endcase
    return v;
  endfunction

  function automatic void model_step(logic r, logic w, int a, logic [31:0] d,
                                     logic [3:0] s, logic [N-1:0] sv);
    int best, bp, id;
    bit np[N], ni[N];
    best = 0; bp = 0;
    // Candidate chosen from the state before the edge.
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i] && !m_isv[i] && m_prio[i] > m_thr && m_prio[i] > bp) begin
        bp = m_prio[i]; best = i + 1;
      end
    for (int i = 0; i < N; i++) begin np[i] = m_pend[i]; ni[i] = m_isv[i]; end
    if (r && a == 4 && m_irq_id != 0) begin
      np[m_irq_id - 1] = 0; ni[m_irq_id - 1] = 1;
    end
    for (int i = 0; i < N; i++) begin
      bit gate;
      gate = m_edge[i] ? (sv[i] && !m_prev[i]) : (sv[i] && !m_isv[i]);
      if (gate) np[i] = 1;
    end
    if (w && model_mapped(a)) begin
      case (a)
        0: begin
`ifdef INTC_SWTRIG_EN
          for (int i = 0; i < N; i++) if (s[i / 8] && d[i]) np[i] = 1;
`endif
        end
        1: for (int i = 0; i < N; i++) if (s[i / 8]) m_en[i] = d[i];
        2: for (int i = 0; i < N; i++) if (s[i / 8]) m_edge[i] = d[i];
        3: if (s[0]) m_thr = int'(d) & PMASK;
        4: if (s[0]) begin
             id = int'(d[4:0]);
             if (id >= 1 && id <= N) ni[id - 1] = 0;
           end
        default:
          for (int i = 0; i < N; i++)
            if (i / 8 == a - 8 && s[(i % 8) / 2]) m_prio[i] = int'(d >> (4 * (i % 8))) & PMASK;
      endcase
    end
    for (int i = 0; i < N; i++) begin m_pend[i] = np[i]; m_isv[i] = ni[i]; m_prev[i] = sv[i]; end
    m_irq_id = best;
    m_irq = (best != 0);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (txn %0d)", nm, act, exp, txn);
    end
  endtask

  // One bus cycle: drive after the falling edge, check combinational outputs,
  // advance the model on the rising edge and check the registered outputs.
  task automatic cyc(input logic r, input logic w, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic [N-1:0] sv);
    logic exp_f;
    logic [31:0] exp_rd;
    @(negedge clk);
    rd_en = r; wr_en = w; addr = a; wr_data = d; wr_strobe = s; src = sv;
    #1;
    last_rd = rd_data;
    last_fault = access_fault;
    if (rst_n) begin
      exp_f  = (r | w) && !model_mapped(int'(a));
      exp_rd = r ? model_read(int'(a)) : 32'h0;
      check("access_fault", 32'(access_fault), 32'(exp_f));
      check("rd_data", rd_data, exp_rd);
    end
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(r, w, int'(a), d, s, sv);
    #1;
    check("irq", 32'(irq), 32'(m_irq));
    check("irq_id", 32'(irq_id), 32'(m_irq_id));
    $display("txn %0d rst_n=%0b rd=%0b wr=%0b addr=%0d wdata=%08h strb=%h src=%03h rd_data=%08h fault=%0b irq=%0b irq_id=%0d",
             txn, rst_n, r, w, a, d, s, sv, last_rd, last_fault, irq, irq_id);
    txn++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         rst;
    logic         r, w;
    logic [3:0]   a;
    logic [31:0]  d;
    logic [3:0]   s;
    logic [N-1:0] sv;
    logic         ck_rd;
    logic [31:0]  exp_rd;
    logic         exp_f;
    logic         ck_irq;
    logic         exp_irq;
    logic [4:0]   exp_id;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rst, logic r, logic w, logic [3:0] a, logic [31:0] d,
                              logic [3:0] s, logic [N-1:0] sv, logic ck_rd, logic [31:0] exp_rd,
                              logic exp_f, logic ck_irq, logic exp_irq, logic [4:0] exp_id);
    vec_t v;
    v.rst = rst; v.r = r; v.w = w; v.a = a; v.d = d; v.s = s; v.sv = sv;
    v.ck_rd = ck_rd; v.exp_rd = exp_rd; v.exp_f = exp_f;
    v.ck_irq = ck_irq; v.exp_irq = exp_irq; v.exp_id = exp_id;
    tbl.push_back(v);
  endfunction

  function automatic void v_rst(logic [N-1:0] sv);
    add(1, 0, 0, 0, 0, 0, sv, 0, 0, 0, 1, 0, 0);
  endfunction
  function automatic void v_wr(logic [3:0] a, logic [31:0] d, logic [3:0] s, logic [N-1:0] sv);
    add(0, 0, 1, a, d, s, sv, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic void v_wri(logic [3:0] a, logic [31:0] d, logic [3:0] s, logic [N-1:0] sv,
                                logic ei, logic [4:0] eid);
    add(0, 0, 1, a, d, s, sv, 0, 0, 0, 1, ei, eid);
  endfunction
  function automatic void v_rd(logic [3:0] a, logic [N-1:0] sv, logic [31:0] e, logic f);
    add(0, 1, 0, a, 0, 0, sv, 1, e, f, 0, 0, 0);
  endfunction
  function automatic void v_idle(logic [N-1:0] sv, logic ei, logic [4:0] eid);
    add(0, 0, 0, 0, 0, 0, sv, 0, 0, 0, 1, ei, eid);
  endfunction

  initial begin
    logic [N-1:0] cur_src;
    model_reset();

    // Reset with all sources high, released with sources low.
    v_rst('1); v_rst('1);
    v_rd(0, 0, 0, 0); v_rd(1, 0, 0, 0); v_rd(2, 0, 0, 0); v_rd(3, 0, 0, 0);
    v_rd(4, 0, 0, 0); v_rd(8, 0, 0, 0); v_rd(9, 0, 0, 0);
    v_idle(0, 0, 0);

    // Level basic
    v_rst(0);
    v_wr(1, 32'h004, 4'hF, 0); v_wr(8, 32'h500, 4'hF, 0); v_wr(3, 0, 4'hF, 0);
    v_idle(10'h004, 0, 0); v_idle(10'h004, 1, 3);
    v_rd(4, 10'h004, 3, 0);
    v_idle(10'h004, 0, 0);
    v_wri(4, 3, 4'h1, 10'h004, 0, 0);
    v_idle(10'h004, 1, 3);

    // Priority and tie-break
    v_rst(0);
    v_wr(1, 32'h052, 4'hF, 0); v_wr(8, 32'h0606_0020, 4'hF, 0);
    v_idle(10'h052, 0, 0); v_idle(0, 1, 5);
    v_rd(4, 0, 5, 0); v_idle(0, 1, 7);
    v_wri(4, 5, 4'h1, 0, 1, 7);
    v_rd(4, 0, 7, 0);
    v_wri(4, 7, 4'h1, 0, 1, 2);
    v_wr(3, 6, 4'hF, 0); v_idle(0, 0, 0);
    v_wr(3, 0, 4'hF, 0); v_idle(0, 1, 2);
    v_rd(4, 0, 2, 0); v_idle(0, 0, 0);

    // Edge mode: second pulse while in service waits for completion
    v_rst(0);
    v_wr(2, 1, 4'hF, 0); v_wr(1, 1, 4'hF, 0); v_wr(8, 1, 4'hF, 0);
    v_idle(1, 0, 0); v_idle(0, 1, 1);
    v_rd(4, 0, 1, 0);
    v_idle(1, 0, 0); v_idle(0, 0, 0); v_idle(0, 0, 0);
    v_wri(4, 1, 4'h1, 0, 0, 0);
    v_idle(0, 1, 1);

    // Faults, strobes, ignored completes
    v_rst(0);
    v_rd(5, 0, 0, 1);
    v_wr(1, 32'hFFFF_FFFF, 4'h1, 0);
    v_rd(1, 0, 32'h0FF, 0);
    v_rd(10, 0, 0, 1); v_rd(12, 0, 0, 1);
    add(0, 0, 1, 7, 32'h1234, 4'hF, 0, 1, 0, 1, 0, 0, 0);
    v_wr(8, 7, 4'hF, 0);
    v_rd(8, 0, 7, 0); v_rd(9, 0, 0, 0);
    v_idle(1, 0, 0); v_idle(1, 1, 1);
    v_rd(4, 1, 1, 0);
    v_wri(4, 0, 4'h1, 1, 0, 0);
    v_wri(4, 20, 4'h1, 1, 0, 0);
    v_wri(4, 1, 4'hE, 1, 0, 0);
    v_idle(1, 0, 0);
    v_wri(4, 1, 4'h1, 1, 0, 0);
    v_idle(1, 1, 1);

    // Software trigger through PENDING
    v_rst(0);
    v_wr(1, 32'h010, 4'hF, 0); v_wr(8, 32'h0003_0000, 4'hF, 0);
    add(0, 0, 1, 0, 32'h010, 4'hF, 0, 1, 0, 0, 1, 0, 0);
`ifdef INTC_SWTRIG_EN
    v_idle(0, 1, 5);
    v_rd(0, 0, 32'h010, 0);
`else
    v_idle(0, 0, 0);
    v_rd(0, 0, 0, 0);
`endif

    foreach (tbl[k]) begin
      rst_n = !tbl[k].rst;
      cyc(tbl[k].r, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].s, tbl[k].sv);
      if (tbl[k].ck_rd) begin
        check($sformatf("vec%0d rd_data", k), last_rd, tbl[k].exp_rd);
        check($sformatf("vec%0d access_fault", k), 32'(last_fault), 32'(tbl[k].exp_f));
      end
      if (tbl[k].ck_irq) begin
        check($sformatf("vec%0d irq", k), 32'(irq), 32'(tbl[k].exp_irq));
        check($sformatf("vec%0d irq_id", k), 32'(irq_id), 32'(tbl[k].exp_id));
      end
    end

    // ---------------- randomized phase vs. model ----------------
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 1, 1, 32'h3FF, 4'hF, 0);
    cyc(0, 1, 8, $urandom, 4'hF, 0);
    cyc(0, 1, 9, $urandom, 4'hF, 0);
    cur_src = '0;
    for (int t = 0; t < 1500; t++) begin
      int op;
      int a;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      cur_src = cur_src ^ N'($urandom & $urandom);
      if (op <= 2) begin
        cyc(0, 0, 0, 0, 0, cur_src);
      end else if (op <= 4) begin
        a = $urandom_range(0, 15);
        cyc(1, 0, AW'(a), 0, 0, cur_src);
      end else if (op == 5) begin
        cyc(1, 0, 4, 0, 0, cur_src);
      end else if (op <= 8) begin
        a = $urandom_range(0, 11);
        d = (a == 3) ? 32'($urandom_range(0, 4)) : $urandom;
        cyc(0, 1, AW'(a), d, 4'($urandom), cur_src);
      end else begin
        d = 32'($urandom_range(0, 12));
        cyc(0, 1, 4, d, ($urandom_range(0, 3) != 0) ? 4'hF : 4'hE, cur_src);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
